alu: RTL and testbench

32-bit arithmetic/logic unit for the Phase 1 datapath. It takes two 32-bit operands and a 4-bit opcode, computes logic, add/sub, negate, multiply, divide, shift or rotate, and registers the result on the clock. It sits between the A/B operand registers and the Z (hi/lo) result register of the CPU datapath.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_div.sv | 32 +++
 rtl/alu.sv | 60 ++++++
 tb/tb_alu.sv | 105 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and data width shared by the ALU and its divider.
package alu_pkg;
    localparam int WORD = 32;
    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SHRA = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
endpackage

// File: rtl/alu_div.sv
// alu_div: combinational signed divider, restoring array on magnitudes with sign fix-up.
module alu_div
    import alu_pkg::*;
(
    input  logic [WORD-1:0] dividend,
    input  logic [WORD-1:0] divisor,
    output logic [WORD-1:0] quotient,
    output logic [WORD-1:0] remainder
);
    logic [WORD-1:0] a_mag;
    logic [WORD-1:0] b_mag;
    logic [WORD-1:0] q_mag;
    logic [WORD:0]   rem;
    always_comb begin
        a_mag = dividend[WORD-1] ? -dividend : dividend;
        b_mag = divisor[WORD-1] ? -divisor : divisor;
        q_mag = '0;
        rem = '0;
        for (int i = WORD - 1; i >= 0; i--) begin
            rem = {rem[WORD-1:0], a_mag[i]};
            if (rem >= {1'b0, b_mag}) begin
                rem = rem - {1'b0, b_mag};
                q_mag[i] = 1'b1;
            end
        end
    end
    // Divide-by-zero is forced explicitly; 0x80000000 / -1 wraps to 0x80000000 naturally.
    assign quotient  = (divisor == '0) ? '1 :
                       (dividend[WORD-1] ^ divisor[WORD-1]) ? -q_mag : q_mag;
    assign remainder = (divisor == '0) ? dividend :
                       dividend[WORD-1] ? -rem[WORD-1:0] : rem[WORD-1:0];
endmodule

// File: rtl/alu.sv
// alu: 32-bit logic/arithmetic/shift unit with registered low and high result words.
module alu
    import alu_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic [WORD-1:0] input_a,
    input  logic [WORD-1:0] input_b,
    input  logic [3:0]      opcode,
    output logic [WORD-1:0] alu_result,
    output logic [WORD-1:0] alu_result_hi
);
    logic [WORD-1:0]   result_d, result_q;
    logic [WORD-1:0]   result_hi_d, result_hi_q;
    logic [2*WORD-1:0] product;
    logic [WORD-1:0]   quotient, remainder;
    logic [4:0]        shamt;
    logic [5:0]        shinv;
    alu_div u_div (
        .dividend  (input_a),
        .divisor   (input_b),
        .quotient  (quotient),
        .remainder (remainder)
    );
    assign product = {{WORD{input_a[WORD-1]}}, input_a} * {{WORD{input_b[WORD-1]}}, input_b};
    assign shamt = input_b[4:0];
    // A shift by 32 yields zero, so rotate-by-0 degrades cleanly to A.
    assign shinv = 6'd32 - {1'b0, shamt};
    always_comb begin
        result_d = '0;
        result_hi_d = '0;
        case (opcode)
            OP_OR:   result_d = input_a | input_b;
            OP_AND:  result_d = input_a & input_b;
            OP_NOT:  result_d = ~input_a;
            OP_ADD:  result_d = input_a + input_b;
            OP_SUB:  result_d = input_a - input_b;
            OP_NEG:  result_d = -input_a;
            OP_MUL:  {result_hi_d, result_d} = product;
            OP_DIV:  {result_hi_d, result_d} = {remainder, quotient};
            OP_SHL:  result_d = input_a << shamt;
            OP_SHR:  result_d = input_a >> shamt;
            OP_SHRA: result_d = $signed(input_a) >>> shamt;
            OP_ROL:  result_d = (input_a << shamt) | (input_a >> shinv);
            OP_ROR:  result_d = (input_a >> shamt) | (input_a << shinv);
            default: result_d = '0;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            result_hi_q <= '0;
        end else begin
            result_q <= result_d;
            result_hi_q <= result_hi_d;
        end
    end
    assign alu_result = result_q;
    assign alu_result_hi = result_hi_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with hand-computed results for every opcode, DIV corners and async reset.
module tb_alu;
    import alu_pkg::*;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] input_a = '0;
    logic [31:0] input_b = '0;
    logic [3:0]  opcode = '0;
    logic [31:0] alu_result;
    logic [31:0] alu_result_hi;
    int tests = 0;
    int fails = 0;
    alu dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .input_a       (input_a),
        .input_b       (input_b),
        .opcode        (opcode),
        .alu_result    (alu_result),
        .alu_result_hi (alu_result_hi)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic [31:0] h);
        @(negedge clock);
        opcode = op;
        input_a = a;
        input_b = b;
        @(posedge clock);
        #1;
        check({tag, ".r"}, alu_result, r);
        check({tag, ".h"}, alu_result_hi, h);
    endtask
    initial begin
        #1;
        check("rst.r", alu_result, 32'h0);
        check("rst.h", alu_result_hi, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        run("or",   OP_OR,  32'd20, 32'd5, 32'd21, 32'h0);
        run("and",  OP_AND, 32'd20, 32'd5, 32'd4, 32'h0);
        run("not",  OP_NOT, 32'd20, 32'd5, 32'hFFFFFFEB, 32'h0);
        run("add",  OP_ADD, 32'd20, 32'd5, 32'd25, 32'h0);
        run("sub",  OP_SUB, 32'd20, 32'd5, 32'd15, 32'h0);
        run("neg",  OP_NEG, 32'd20, 32'd5, 32'hFFFFFFEC, 32'h0);
        run("mul",  OP_MUL, 32'd20, 32'd5, 32'd100, 32'h0);
        run("div",  OP_DIV, 32'd20, 32'd5, 32'd4, 32'h0);
        run("addwrap", OP_ADD, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        run("subwrap", OP_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 32'h0);
        run("muls", OP_MUL, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 32'hFFFFFFFF);
        run("mulbig", OP_MUL, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000);
        run("hiclr", OP_OR, 32'd0, 32'd0, 32'h0, 32'h0);
        run("divs", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run("divnb", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        run("divnn", OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
        run("div0", OP_DIV, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd7);
        run("div0n", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9);
        run("divov", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
        run("divbig", OP_DIV, 32'd1000000, 32'd7, 32'd142857, 32'd1);
        run("shl",  OP_SHL, 32'hB2, 32'd2, 32'h2C8, 32'h0);
        run("shr",  OP_SHR, 32'hB2, 32'd2, 32'h2C, 32'h0);
        run("rol",  OP_ROL, 32'hB2, 32'd2, 32'h2C8, 32'h0);
        run("ror",  OP_ROR, 32'hB2, 32'd2, 32'h8000002C, 32'h0);
        run("rolw", OP_ROL, 32'h80000001, 32'd1, 32'h3, 32'h0);
        run("shra", OP_SHRA, 32'h80000000, 32'd4, 32'hF8000000, 32'h0);
        run("shrap", OP_SHRA, 32'h40000000, 32'd4, 32'h04000000, 32'h0);
        run("shr4", OP_SHR, 32'h80000000, 32'd4, 32'h08000000, 32'h0);
        run("shl0", OP_SHL, 32'hB2, 32'd32, 32'hB2, 32'h0);
        run("shr0", OP_SHR, 32'hB2, 32'd32, 32'hB2, 32'h0);
        run("ror0", OP_ROR, 32'hB2, 32'd32, 32'hB2, 32'h0);
        run("rol0", OP_ROL, 32'hB2, 32'd32, 32'hB2, 32'h0);
        run("shlhi", OP_SHL, 32'h1, 32'hFFFFFFE3, 32'h8, 32'h0);
        run("rsv13", 4'd13, 32'd20, 32'd5, 32'h0, 32'h0);
        run("rsv14", 4'd14, 32'd20, 32'd5, 32'h0, 32'h0);
        run("rsv15", 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
        run("preload", OP_MUL, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 32'hFFFFFFFF);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.r", alu_result, 32'h0);
        check("arst.h", alu_result_hi, 32'h0);
        opcode = OP_SUB;
        input_a = 32'd20;
        input_b = 32'd5;
        @(posedge clock);
        #1;
        check("hold.r", alu_result, 32'h0);
        check("hold.h", alu_result_hi, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rel.r", alu_result, 32'd15);
        check("rel.h", alu_result_hi, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
